// File: rtl/tile_scheduler.sv
// tile_scheduler
//   Walks an M x N x K problem in Tm x Tn x Tk tiles (k innermost, then n,
//   then m outermost) and hands one tile at a time to a compute core.
//   Dimensions and tile sizes are captured into shadow registers when a run
//   is accepted, so CSR writes during a run have no effect on it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start_pulse, abort_pulse  single-cycle run / abort requests from CSR
//   M, N, K, Tm, Tn, Tk       problem dimensions and tile sizes
//   tile_done                 core pulse: current tile finished
//   tile_start                pulse: core begins the presented tile
//   m_idx, n_idx, k_idx       element offset of the current tile
//   m_len, n_len, k_len       valid extent of the current tile (edge tiles shortened)
//   k_first, k_last           tile is first / last along K
//   bank_sel_rd               ping-pong read bank, toggles per completed tile
//   busy, done_pulse          status and end-of-run pulse
//   abort_ack, cfg_err        abort acknowledge, rejected-start pulse
//   tiles_done                tiles completed in current/last run (saturating)
//
// State  | meaning
// IDLE    | no run active; results of the last run held
// ISSUE   | tile_start pulsed for the presented tile
// WAIT    | core working; waiting for tile_done
// ADVANCE | step indices to the next tile or detect end of run
// FINISH  | done_pulse for one cycle
module tile_scheduler #(
    parameter int DIM_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             abort_pulse,
    input  logic [DIM_W-1:0] M,
    input  logic [DIM_W-1:0] N,
    input  logic [DIM_W-1:0] K,
    input  logic [DIM_W-1:0] Tm,
    input  logic [DIM_W-1:0] Tn,
    input  logic [DIM_W-1:0] Tk,
    input  logic             tile_done,
    output logic             tile_start,
    output logic [DIM_W-1:0] m_idx,
    output logic [DIM_W-1:0] n_idx,
    output logic [DIM_W-1:0] k_idx,
    output logic [DIM_W-1:0] m_len,
    output logic [DIM_W-1:0] n_len,
    output logic [DIM_W-1:0] k_len,
    output logic             k_first,
    output logic             k_last,
    output logic             bank_sel_rd,
    output logic             busy,
    output logic             done_pulse,
    output logic             abort_ack,
    output logic             cfg_err,
    output logic [CNT_W-1:0] tiles_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [DIM_W-1:0] m_dim, n_dim, k_dim;
    logic [DIM_W-1:0] m_tile, n_tile, k_tile;
    // Set once a run has been accepted; keeps k_first/k_last low after reset
    // while the shadow registers are still all zero.
    logic             loaded;

    logic             cfg_ok;
    logic             start_ok;
    logic             abort_req;

    // One extra bit so idx + tile never aliases back below the dimension.
    logic [DIM_W:0]   m_sum, n_sum, k_sum;
    logic             m_wrap, n_wrap, k_wrap;
    logic             last_tile;
    logic [DIM_W-1:0] m_rem, n_rem, k_rem;

    assign cfg_ok    = (|M) && (|N) && (|K) && (|Tm) && (|Tn) && (|Tk);
    assign start_ok  = (state == IDLE) && start_pulse && cfg_ok;
    assign abort_req = abort_pulse && (state != IDLE);

    assign m_sum     = {1'b0, m_idx} + {1'b0, m_tile};
    assign n_sum     = {1'b0, n_idx} + {1'b0, n_tile};
    assign k_sum     = {1'b0, k_idx} + {1'b0, k_tile};
    assign m_wrap    = m_sum >= {1'b0, m_dim};
    assign n_wrap    = n_sum >= {1'b0, n_dim};
    assign k_wrap    = k_sum >= {1'b0, k_dim};
    assign last_tile = k_wrap && n_wrap && m_wrap;

    // Indices always stay below their dimension, so these never underflow.
    assign m_rem = m_dim - m_idx;
    assign n_rem = n_dim - n_idx;
    assign k_rem = k_dim - k_idx;

    assign m_len   = (m_tile < m_rem) ? m_tile : m_rem;
    assign n_len   = (n_tile < n_rem) ? n_tile : n_rem;
    assign k_len   = (k_tile < k_rem) ? k_tile : k_rem;
    assign k_first = loaded && (k_idx == '0);
    assign k_last  = loaded && k_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tile_start = 1'b0;
        done_pulse = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tile_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (tile_done) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                state_next = last_tile ? FINISH : ISSUE;
            end
            FINISH: begin
                done_pulse = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_req) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_dim       <= '0;
            n_dim       <= '0;
            k_dim       <= '0;
            m_tile      <= '0;
            n_tile      <= '0;
            k_tile      <= '0;
            m_idx       <= '0;
            n_idx       <= '0;
            k_idx       <= '0;
            loaded      <= 1'b0;
            bank_sel_rd <= 1'b0;
            tiles_done  <= '0;
            abort_ack   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            abort_ack <= abort_req;
            cfg_err   <= (state == IDLE) && start_pulse && !cfg_ok;

            if (start_ok) begin
                m_dim       <= M;
                n_dim       <= N;
                k_dim       <= K;
                m_tile      <= Tm;
                n_tile      <= Tn;
                k_tile      <= Tk;
                m_idx       <= '0;
                n_idx       <= '0;
                k_idx       <= '0;
                loaded      <= 1'b1;
                bank_sel_rd <= 1'b0;
                tiles_done  <= '0;
            end

            // Abort beats a coincident tile_done: the tile is not counted.
            if ((state == WAIT) && tile_done && !abort_pulse) begin
                bank_sel_rd <= ~bank_sel_rd;
                if (tiles_done != {CNT_W{1'b1}}) begin
                    tiles_done <= tiles_done + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            // On the final tile the indices are left alone so they still
            // describe the last tile while idle.
            if ((state == ADVANCE) && !abort_pulse && !last_tile) begin
                if (!k_wrap) begin
                    k_idx <= k_sum[DIM_W-1:0];
                end else begin
                    k_idx <= '0;
                    if (!n_wrap) begin
                        n_idx <= n_sum[DIM_W-1:0];
                    end else begin
                        n_idx <= '0;
                        m_idx <= m_sum[DIM_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

    localparam int DIM_W = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_pulse;
    logic             abort_pulse;
    logic [DIM_W-1:0] M, N, K, Tm, Tn, Tk;
    logic             tile_done;
    logic             tile_start;
    logic [DIM_W-1:0] m_idx, n_idx, k_idx;
    logic [DIM_W-1:0] m_len, n_len, k_len;
    logic             k_first, k_last;
    logic             bank_sel_rd;
    logic             busy, done_pulse, abort_ack, cfg_err;
    logic [CNT_W-1:0] tiles_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_scheduler #(.DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .start_pulse(start_pulse), .abort_pulse(abort_pulse),
        .M(M), .N(N), .K(K), .Tm(Tm), .Tn(Tn), .Tk(Tk),
        .tile_done(tile_done), .tile_start(tile_start),
        .m_idx(m_idx), .n_idx(n_idx), .k_idx(k_idx),
        .m_len(m_len), .n_len(n_len), .k_len(k_len),
        .k_first(k_first), .k_last(k_last),
        .bank_sel_rd(bank_sel_rd), .busy(busy),
        .done_pulse(done_pulse), .abort_ack(abort_ack), .cfg_err(cfg_err),
        .tiles_done(tiles_done)
    );

    typedef struct {
        int mi, ni, ki, ml, nl, kl;
        bit kf, kz;
    } tile_t;

    tile_t tbl[14];

    function automatic tile_t mk(int mi, int ni, int ki, int ml, int nl, int kl, bit kf, bit kz);
        tile_t t;
        t.mi = mi; t.ni = ni; t.ki = ki;
        t.ml = ml; t.nl = nl; t.kl = kl;
        t.kf = kf; t.kz = kz;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic set_dims(input int m, input int n, input int k,
                            input int tm, input int tn, input int tk);
        M = DIM_W'(m); N = DIM_W'(n); K = DIM_W'(k);
        Tm = DIM_W'(tm); Tn = DIM_W'(tn); Tk = DIM_W'(tk);
    endtask

    task automatic chk_tile(input int i);
        chk($sformatf("t%0d tile_start", i), tile_start, 1);
        chk($sformatf("t%0d m_idx", i), m_idx, tbl[i].mi);
        chk($sformatf("t%0d n_idx", i), n_idx, tbl[i].ni);
        chk($sformatf("t%0d k_idx", i), k_idx, tbl[i].ki);
        chk($sformatf("t%0d m_len", i), m_len, tbl[i].ml);
        chk($sformatf("t%0d n_len", i), n_len, tbl[i].nl);
        chk($sformatf("t%0d k_len", i), k_len, tbl[i].kl);
        chk($sformatf("t%0d k_first", i), k_first, tbl[i].kf);
        chk($sformatf("t%0d k_last", i), k_last, tbl[i].kz);
    endtask

    // Called at the negedge where tile_start is high. tile_done is returned
    // three cycles after tile_start; next tile_start / done_pulse two cycles later.
    task automatic do_tile(input int i, input bit last, input bit poke_start);
        chk_tile(i);
        @(negedge clk);
        chk("tile_start width", tile_start, 0);
        if (poke_start) start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        @(negedge clk);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk("busy in advance", busy, 1);
        @(negedge clk);
        if (last) begin
            chk("done_pulse latency", done_pulse, 1);
            chk("no tile_start at finish", tile_start, 0);
        end else begin
            chk("tile_start latency", tile_start, 1);
        end
    endtask

    task automatic run(input int first, input int count, input bit change_csr);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        if (change_csr) set_dims(7, 7, 7, 1, 1, 1);
        chk("start latency", tile_start, 1);
        for (int i = 0; i < count; i++) begin
            do_tile(first + i, i == count - 1, i == 1);
        end
        chk("run tiles_done", tiles_done, count);
        chk("run bank_sel_rd", bank_sel_rd, 0);
        @(negedge clk);
        chk("idle after finish", busy, 0);
        chk("single done_pulse", done_pulse, 0);
        chk("held m_idx", m_idx, tbl[first + count - 1].mi);
        chk("held k_idx", k_idx, tbl[first + count - 1].ki);
    endtask

    initial begin
        // 4x4x4 with 2x2x2 tiles
        for (int i = 0; i < 8; i++) begin
            tbl[i] = mk(((i >> 2) & 1) * 2, ((i >> 1) & 1) * 2, (i & 1) * 2,
                        2, 2, 2, (i & 1) == 0, (i & 1) == 1);
        end
        // M=5 N=2 K=3 with 2x2x2 tiles
        tbl[8]  = mk(0, 0, 0, 2, 2, 2, 1, 0);
        tbl[9]  = mk(0, 0, 2, 2, 2, 1, 0, 1);
        tbl[10] = mk(2, 0, 0, 2, 2, 2, 1, 0);
        tbl[11] = mk(2, 0, 2, 2, 2, 1, 0, 1);
        tbl[12] = mk(4, 0, 0, 1, 2, 2, 1, 0);
        tbl[13] = mk(4, 0, 2, 1, 2, 1, 0, 1);

        rst = 1'b1; start_pulse = 1'b0; abort_pulse = 1'b0; tile_done = 1'b0;
        set_dims(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst busy", busy, 0);
        chk("rst tile_start", tile_start, 0);
        chk("rst tiles_done", tiles_done, 0);
        chk("rst m_idx", m_idx, 0);
        chk("rst k_len", k_len, 0);
        chk("rst k_first", k_first, 0);
        chk("rst k_last", k_last, 0);
        chk("rst bank", bank_sel_rd, 0);

        // abort and tile_done in IDLE are ignored
        abort_pulse = 1'b1; tile_done = 1'b1;
        @(negedge clk);
        abort_pulse = 1'b0; tile_done = 1'b0;
        @(negedge clk);
        chk("idle abort_ack", abort_ack, 0);
        chk("idle tiles_done", tiles_done, 0);
        chk("idle busy", busy, 0);

        // Zero tile size rejected
        set_dims(4, 4, 4, 2, 2, 0);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        chk("cfg_err pulse", cfg_err, 1);
        chk("cfg_err busy", busy, 0);
        chk("cfg_err tile_start", tile_start, 0);
        @(negedge clk);
        chk("cfg_err width", cfg_err, 0);
        chk("cfg_err busy later", busy, 0);
        chk("cfg_err no tile_start", tile_start, 0);

        // Full 4x4x4 run, with a stray start_pulse mid-run
        set_dims(4, 4, 4, 2, 2, 2);
        run(0, 8, 1'b0);

        // Edge tiles; CSR inputs changed during the run
        set_dims(5, 2, 3, 2, 2, 2);
        run(8, 6, 1'b1);

        // Abort coinciding with tile_done of the third tile
        set_dims(4, 4, 4, 2, 2, 2);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        do_tile(0, 1'b0, 1'b0);
        do_tile(1, 1'b0, 1'b0);
        chk_tile(2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tile_done = 1'b1; abort_pulse = 1'b1;
        @(negedge clk);
        tile_done = 1'b0; abort_pulse = 1'b0;
        chk("abort_ack", abort_ack, 1);
        chk("abort busy", busy, 0);
        chk("abort tiles_done", tiles_done, 2);
        chk("abort bank", bank_sel_rd, 0);
        chk("abort tile_start", tile_start, 0);
        @(negedge clk);
        chk("abort_ack width", abort_ack, 0);
        chk("abort no done_pulse", done_pulse, 0);
        chk("abort no tile_start", tile_start, 0);
        @(negedge clk);
        chk("abort no done_pulse later", done_pulse, 0);

        // Reset during WAIT of the second tile, with tile_done pending
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        do_tile(0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; tile_done = 1'b1;
        @(negedge clk);
        rst = 1'b0; tile_done = 1'b0;
        chk("mid rst busy", busy, 0);
        chk("mid rst tiles_done", tiles_done, 0);
        chk("mid rst k_idx", k_idx, 0);
        chk("mid rst m_len", m_len, 0);
        chk("mid rst bank", bank_sel_rd, 0);
        chk("mid rst k_first", k_first, 0);
        @(negedge clk);
        chk("mid rst stays idle", busy, 0);
        chk("mid rst tiles_done held", tiles_done, 0);

        // 1x1x1 run; tile_done during ISSUE is ignored
        set_dims(1, 1, 1, 1, 1, 1);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        chk("one tile_start", tile_start, 1);
        chk("one m_idx", m_idx, 0);
        chk("one n_idx", n_idx, 0);
        chk("one k_idx", k_idx, 0);
        chk("one m_len", m_len, 1);
        chk("one n_len", n_len, 1);
        chk("one k_len", k_len, 1);
        chk("one k_first", k_first, 1);
        chk("one k_last", k_last, 1);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk("issue tile_done ignored", tiles_done, 0);
        chk("issue tile_done busy", busy, 1);
        @(negedge clk);
        chk("still waiting", tiles_done, 0);
        chk("still waiting no tile_start", tile_start, 0);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk("one tiles_done", tiles_done, 1);
        chk("one bank", bank_sel_rd, 1);
        @(negedge clk);
        chk("one done_pulse", done_pulse, 1);
        @(negedge clk);
        chk("one idle", busy, 0);
        chk("one tiles_done held", tiles_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter DIM_W, default 16, width of all dimension, tile-size and index ports.
REQ-002 SHALL have parameter CNT_W, default 32, width of tiles_done counter.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge; one clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start_pulse  input  1  single-cycle run request from CSR block.
REQ-006 SHALL have port abort_pulse  input  1  single-cycle abort request from CSR block.
REQ-007 SHALL have ports M, N, K  input  DIM_W each  problem dimensions.
REQ-008 SHALL have ports Tm, Tn, Tk  input  DIM_W each  tile sizes.
REQ-009 SHALL have port tile_done  input  1  core pulse: current tile finished.
REQ-010 SHALL have port tile_start  output  1  single-cycle pulse: core begins tile.
REQ-011 SHALL have ports m_idx, n_idx, k_idx  output  DIM_W each  element offset of current tile.
REQ-012 SHALL have ports m_len, n_len, k_len  output  DIM_W each  valid extent of current tile.
REQ-013 SHALL have ports k_first, k_last  output  1 each  current tile is first/last along K (accumulator clear/drain).
REQ-014 SHALL have port bank_sel_rd  output  1  ping-pong read-bank select toward core.
REQ-015 SHALL have ports busy, done_pulse, abort_ack, cfg_err  output  1 each  status/pulses back to CSR.
REQ-016 SHALL have port tiles_done  output  CNT_W  tiles completed in current/last run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, ADVANCE, FINISH.
REQ-018 IDLE + start_pulse with M,N,K,Tm,Tn,Tk all nonzero: latch all six into shadow regs, zero indices, bank_sel_rd, tiles_done; go to ISSUE.
REQ-019 IDLE + start_pulse with any of the six zero: stay IDLE, cfg_err high one cycle next cycle, no other output changes.
REQ-020 ISSUE: tile_start high exactly this one cycle; next state WAIT.
REQ-021 WAIT: hold until tile_done; then ADVANCE, tiles_done +1, bank_sel_rd toggles.
REQ-022 tile_done outside WAIT SHALL be ignored.
REQ-023 ADVANCE: loop order k innermost, then n, then m outermost; each index steps by its tile size.
REQ-024 Step arithmetic SHALL use DIM_W+1 bits; sum >= dimension wraps index to 0 and carries to next loop; no DIM_W overflow aliasing.
REQ-025 ADVANCE with carry out of m loop: go to FINISH; otherwise ISSUE.
REQ-026 FINISH: done_pulse high this one cycle; next IDLE.
REQ-027 len = min(tile size, dimension - idx) per axis, from latched values; edge tiles shortened.
REQ-028 k_first = (k_idx==0); k_last = (k_idx + Tk >= K).
REQ-029 busy high in every state except IDLE.
REQ-030 Latency: start_pulse cycle t -> tile_start cycle t+1; tile_done cycle c -> next tile_start c+2 or done_pulse c+2.
REQ-031 abort_pulse in any non-IDLE state: next state IDLE, abort_ack high one cycle, no tile_start, no done_pulse.
REQ-032 abort_pulse with tile_done same cycle: abort wins; tiles_done, bank_sel_rd not updated.
REQ-033 abort_pulse in IDLE: ignored; start_pulse while busy: ignored.
REQ-034 CSR changes to M..Tk during a run SHALL NOT affect it (shadow regs only).
REQ-035 tiles_done and indices SHALL hold last values in IDLE until next accepted start.
REQ-036 tiles_done SHALL saturate at all-ones.

Reset
REQ-037 rst high at any clock edge, including mid-run: state IDLE; all outputs, indices, lens, shadow regs, tiles_done, bank_sel_rd to 0; pending tile_done discarded.

Verification
REQ-038 M=N=K=4, Tm=Tn=Tk=2, tile_done 3 cycles after each tile_start -> 8 tile_starts, (m,n,k) = (0,0,0),(0,0,2),(0,2,0),(0,2,2),(2,0,0)...(2,2,2); tiles_done=8; one done_pulse; bank_sel_rd ends 0.
REQ-039 M=5,N=2,K=3, Tm=2,Tn=2,Tk=2 -> 6 tiles; m_idx 0,2,4 with m_len 2,2,1; k_len 2 then 1; k_last on k_idx=2 only.
REQ-040 Tk=0, start_pulse -> cfg_err one cycle, busy stays 0, no tile_start.
REQ-041 abort_pulse in WAIT of tile 3, same cycle as tile_done -> abort_ack next cycle, IDLE, tiles_done=2, no done_pulse.
REQ-042 tile_done pulsed in ISSUE cycle and in IDLE -> ignored, tiles_done unchanged.
REQ-043 rst asserted during WAIT, then new start with M=N=K=Tm=Tn=Tk=1 -> single tile at (0,0,0), lens 1, k_first=k_last=1, tiles_done=1.
